// File: rtl/sobel_window_sequencer.sv
// rtl/sobel_window_sequencer.sv - walks interior pixels, fetches 3x3 windows, issues them over valid/ready
// One buffer read per cycle; centre address advanced incrementally so no multiplier is needed.
module sobel_window_sequencer #(
   parameter int HEIGHT = 120,
   parameter int WIDTH  = 160,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [71:0]       win_data,
   output logic [ADDR_W-1:0] win_addr
);

   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

   state_t              state, state_n;
   logic [3:0]          cnt, cnt_n;
   logic [XW-1:0]       cx, cx_n;
   logic [YW-1:0]       cy, cy_n;
   logic [ADDR_W-1:0]   caddr, caddr_n;
   logic [71:0]         win_data_n;
   logic [ADDR_W-1:0]   win_addr_n, rd_addr_n;
   logic                rd_en_n, win_valid_n, busy_n, done_n;

   // Offset of tap k from the top-left neighbour of the centre.
   function automatic logic [ADDR_W-1:0] tap_off(input logic [3:0] k);
      logic [ADDR_W-1:0] w;
      w = ADDR_W'(WIDTH);
      case (k)
         4'd1:    tap_off = ADDR_W'(1);
         4'd2:    tap_off = ADDR_W'(2);
         4'd3:    tap_off = w;
         4'd4:    tap_off = w + ADDR_W'(1);
         4'd5:    tap_off = w + ADDR_W'(2);
         4'd6:    tap_off = w + w;
         4'd7:    tap_off = w + w + ADDR_W'(1);
         4'd8:    tap_off = w + w + ADDR_W'(2);
         default: tap_off = '0;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         cx        <= XW'(1);
         cy        <= YW'(1);
         caddr     <= ADDR_W'(WIDTH + 1);
         win_data  <= '0;
         win_addr  <= '0;
         rd_addr   <= '0;
         rd_en     <= 1'b0;
         win_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         cx        <= cx_n;
         cy        <= cy_n;
         caddr     <= caddr_n;
         win_data  <= win_data_n;
         win_addr  <= win_addr_n;
         rd_addr   <= rd_addr_n;
         rd_en     <= rd_en_n;
         win_valid <= win_valid_n;
         busy      <= busy_n;
         done      <= done_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      cx_n       = cx;
      cy_n       = cy;
      caddr_n    = caddr;
      win_data_n = win_data;
      win_addr_n = win_addr;
      case (state)
         S_IDLE: begin
            cx_n    = XW'(1);
            cy_n    = YW'(1);
            caddr_n = ADDR_W'(WIDTH + 1);
            cnt_n   = '0;
            if (start) state_n = S_FETCH;
         end
         S_FETCH: begin
            // Data for the read issued last cycle lands in tap cnt-1.
            for (int k = 0; k < 9; k++)
               if (cnt == 4'(k + 1)) win_data_n[8*k +: 8] = rd_data;
            if (cnt == 4'd9) begin
               state_n    = S_ISSUE;
               win_addr_n = caddr;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         S_ISSUE: begin
            if (win_ready) begin
               if (cx == XW'(WIDTH - 2) && cy == YW'(HEIGHT - 2)) begin
                  state_n = S_DONE;
               end else begin
                  if (cx == XW'(WIDTH - 2)) begin
                     cx_n    = XW'(1);
                     cy_n    = cy + YW'(1);
                     caddr_n = caddr + ADDR_W'(3);
                  end else begin
                     cx_n    = cx + XW'(1);
                     caddr_n = caddr + ADDR_W'(1);
                  end
                  cnt_n   = '0;
                  state_n = S_FETCH;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase

      // Outputs are registered from the next-state values so they line up with the state they describe.
      rd_en_n     = (state_n == S_FETCH) && (cnt_n <= 4'd8);
      rd_addr_n   = rd_en_n ? (caddr_n - ADDR_W'(WIDTH + 1) + tap_off(cnt_n)) : rd_addr;
      win_valid_n = (state_n == S_ISSUE);
      busy_n      = (state_n != S_IDLE);
      done_n      = (state_n == S_DONE);
   end

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// tb/tb_sobel_window_sequencer.sv - randomized self-checking bench against a frame-level window model
module tb_sobel_window_sequencer;

   localparam int H  = 4;
   localparam int W  = 5;
   localparam int AW = 15;
   localparam int N  = (H - 2) * (W - 2);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, rd_en, win_valid;
   logic          win_ready = 1'b0;
   logic [AW-1:0] rd_addr, win_addr;
   logic [7:0]    rd_data = 8'h00;
   logic [71:0]   win_data;

   sobel_window_sequencer #(.HEIGHT(H), .WIDTH(W), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .win_valid(win_valid), .win_ready(win_ready),
      .win_data(win_data), .win_addr(win_addr)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [H*W];
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   logic [AW-1:0] obs_addr[$], obs_reads[$], exp_addr[$], exp_reads[$];
   logic [71:0]   obs_data[$], exp_data[$];
   int            done_cnt = 0, rd_in_issue = 0;
   int            n_pass = 0, n_total = 0;

   always @(negedge clk) begin
      if (win_valid && win_ready) begin
         obs_addr.push_back(win_addr);
         obs_data.push_back(win_data);
      end
      if (rd_en) obs_reads.push_back(rd_addr);
      if (rd_en && win_valid) rd_in_issue++;
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   task automatic clear_mon();
      obs_addr.delete(); obs_data.delete(); obs_reads.delete();
      done_cnt = 0; rd_in_issue = 0;
   endtask

   // Expected windows in raster order, computed directly from the frame contents.
   task automatic build_model();
      logic [71:0] d;
      exp_addr.delete(); exp_data.delete(); exp_reads.delete();
      for (int y = 1; y <= H - 2; y++)
         for (int x = 1; x <= W - 2; x++) begin
            for (int dy = 0; dy < 3; dy++)
               for (int dx = 0; dx < 3; dx++) begin
                  d[8*(3*dy+dx) +: 8] = mem[(y+dy-1)*W + (x+dx-1)];
                  exp_reads.push_back(AW'((y+dy-1)*W + (x+dx-1)));
               end
            exp_addr.push_back(AW'(y*W + x));
            exp_data.push_back(d);
         end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_busy"}, 72'(busy), 72'(0));
      check({pfx, "_done"}, 72'(done), 72'(0));
      check({pfx, "_rd_en"}, 72'(rd_en), 72'(0));
      check({pfx, "_win_valid"}, 72'(win_valid), 72'(0));
      check({pfx, "_rd_addr"}, 72'(rd_addr), 72'(0));
      check({pfx, "_win_addr"}, 72'(win_addr), 72'(0));
      check({pfx, "_win_data"}, win_data, 72'(0));
   endtask

   task automatic compare_frame(input string pfx);
      check({pfx, "_nwin"}, 72'(obs_addr.size()), 72'(N));
      for (int i = 0; i < N && i < obs_addr.size(); i++) begin
         check($sformatf("%s_addr%0d", pfx, i), 72'(obs_addr[i]), 72'(exp_addr[i]));
         check($sformatf("%s_data%0d", pfx, i), obs_data[i], exp_data[i]);
      end
      check({pfx, "_nreads"}, 72'(obs_reads.size()), 72'(9*N));
      for (int i = 0; i < 9*N && i < obs_reads.size(); i++)
         check($sformatf("%s_read%0d", pfx, i), 72'(obs_reads[i]), 72'(exp_reads[i]));
      check({pfx, "_rd_in_issue"}, 72'(rd_in_issue), 72'(0));
      check({pfx, "_done_cnt"}, 72'(done_cnt), 72'(1));
   endtask

   // mode 0: ready tied high with timing checks; mode 1: random ready, stall on window 2, ignored starts.
   task automatic run_frame(input int mode, input string pfx);
      int cyc, done_cyc, vcyc, frd, stalled, stable;
      logic [71:0] sd;
      logic [AW-1:0] sa;
      clear_mon();
      build_model();
      cyc = 0; done_cyc = -1; vcyc = -1; frd = -1; stalled = 0;
      win_ready = (mode == 0);
      @(posedge clk); #1 start = 1'b1;
      while (cyc < 3000 && done_cyc < 0) begin
         @(posedge clk); #1;
         cyc++;
         start = (mode == 1) && (cyc == 3 || cyc == 11);
         if (rd_en && frd < 0) frd = cyc;
         if (win_valid && vcyc < 0) vcyc = cyc;
         if (done) done_cyc = cyc;
         if (mode == 1 && stalled == 0 && obs_addr.size() == 1 && win_valid) begin
            stalled = 1; stable = 1;
            win_ready = 1'b0; sd = win_data; sa = win_addr;
            repeat (20) begin
               @(posedge clk); #1;
               cyc++;
               if (!(win_valid && win_data === sd && win_addr === sa && !rd_en)) stable = 0;
            end
            check({pfx, "_stall_hold"}, 72'(stable), 72'(1));
         end else if (mode == 1) begin
            win_ready = 1'($urandom_range(0, 1));
         end
      end
      start = 1'b0;
      check({pfx, "_done_seen"}, 72'(done_cyc >= 0), 72'(1));
      if (mode == 0) begin
         check({pfx, "_first_rd_cyc"}, 72'(frd), 72'(1));
         check({pfx, "_first_valid_cyc"}, 72'(vcyc), 72'(11));
         check({pfx, "_frame_latency"}, 72'(done_cyc + 1), 72'(11*N + 2));
      end else begin
         check({pfx, "_stalled"}, 72'(stalled), 72'(1));
      end
      win_ready = 1'b1;
      @(posedge clk); #1;
      check({pfx, "_busy_after"}, 72'(busy), 72'(0));
      check({pfx, "_done_after"}, 72'(done), 72'(0));
      repeat (3) @(posedge clk);
      #1 compare_frame(pfx);
   endtask

   initial begin
      int guard;
      #2 rst = 1'b1;
      #1 check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Basic frame: buffer holds its own address.
      for (int i = 0; i < H*W; i++) mem[i] = 8'(i);
      run_frame(0, "basic");
      check("basic_first_taps", obs_data.size() > 0 ? obs_data[0] : 72'(0), 72'h0C_0B_0A_07_06_05_02_01_00);

      // Random contents with backpressure and ignored starts.
      for (int i = 0; i < H*W; i++) mem[i] = 8'($urandom);
      run_frame(1, "random");

      // Reset during FETCH of window 3.
      clear_mon();
      win_ready = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      guard = 0;
      while (!(obs_addr.size() == 2 && rd_en) && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      check("midrst_reached_fetch3", 72'(guard < 200), 72'(1));
      #2 rst = 1'b1;
      #1 check_reset_outputs("midrst");
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("midrst_no_done", 72'(done_cnt), 72'(0));
      check("midrst_idle_busy", 72'(busy), 72'(0));

      // Fresh frame after the aborted one must start from the first centre.
      for (int i = 0; i < H*W; i++) mem[i] = 8'($urandom);
      run_frame(0, "restart");
      check("restart_first_addr", obs_addr.size() > 0 ? 72'(obs_addr[0]) : 72'(0), 72'(W + 1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
